// File: rtl/gate_test_pkg.sv
// gate_test_pkg
// Shared definitions for the gate truth-table checker:
//   - state_e      : checker sequencing states (IDLE, SETTLE, DONE)
//   - NUM_VECTORS  : number of input vectors for a 2-input gate
//   - TT_*         : expected-output tables for common gates, indexed by {A,B}
//                    (bit0 = 00, bit1 = 01, bit2 = 10, bit3 = 11)
package gate_test_pkg;

  localparam int NUM_VECTORS = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// settle_timer
// Counts the clock edges a stimulus vector has been held. expire is high
// during the cycle whose closing edge is the SETTLE_CYCLES-th edge since the
// last clear/expire, i.e. the edge on which the output should be sampled.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset
//   clear  in  force the count back to zero (takes priority over run)
//   run    in  count while high
//   expire out settle period complete on the coming edge
module settle_timer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("settle_timer: SETTLE_CYCLES must be >= 1");
  end

  localparam int              CW   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = expire ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Hardware checker that sits beside a 2-input combinational gate. It drives
// the vectors {A,B} = 00, 01, 10, 11 in turn, holds each for SETTLE_CYCLES
// edges, samples the gate output Y and compares it with TRUTH_TABLE.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a sweep (honoured only in IDLE or DONE)
//   abort      in   cancel a sweep in progress (partial results kept)
//   Y          in   output of the gate under check (must be 0/1)
//   A, B       out  stimulus; {A,B} is the vector index
//   busy       out  sweep in progress
//   done       out  sweep completed (level, held until next start/reset)
//   pass       out  done and no mismatches
//   err_count  out  number of mismatching vectors (0..4)
//   fail_vec   out  bit i set when vector i mismatched
module gate_truth_checker
  import gate_test_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_XNOR,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] err_count_q, err_count_d;
  logic [3:0] fail_vec_q, fail_vec_d;

  logic timer_clear;
  logic timer_run;
  logic timer_expire;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .run   (timer_run),
    .expire(timer_expire)
  );

  assign timer_run = (state_q == SETTLE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ab_d        = ab_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    timer_clear = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // start outranks abort here; abort has no meaning outside a sweep.
        if (start) begin
          state_d     = SETTLE;
          idx_d       = 2'd0;
          ab_d        = 2'd0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_count_d = 3'd0;
          fail_vec_d  = 4'd0;
          timer_clear = 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          // Abort wins over a coincident sample: that vector is not recorded.
          state_d     = IDLE;
          ab_d        = 2'd0;
          busy_d      = 1'b0;
          timer_clear = 1'b1;
        end else if (timer_expire) begin
          if (Y != TRUTH_TABLE[idx_q]) begin
            fail_vec_d[idx_q] = 1'b1;
            // Each vector is sampled once per sweep, so this stops at 4.
            err_count_d = err_count_q + 3'd1;
          end
          if (idx_q == 2'(NUM_VECTORS - 1)) begin
            state_d = DONE;
            ab_d    = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
            ab_d  = idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        ab_d    = 2'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      ab_q        <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= 3'd0;
      fail_vec_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ab_q        <= ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  assign A         = ab_q[1];
  assign B         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_count_q == 3'd0);
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
